// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-side SRAM responder.
// Holds the bus widths, FSM states and the out-of-range address check.
package dmem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int WEN_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

  // Any address bit above the word index makes the access out of range.
  function automatic logic word_oor(input logic [ADDR_W-1:0] addr, input int aw);
    return |(addr >> (aw + 2));
  endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of data RAM: single write port, registered read port.
// The read register loads only on i_re, so it holds the last read result.
module dmem_byte_bank #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       o_rdata <= 8'h00;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data SRAM responder: byte-lane writes, word reads with optional wait states.
// Stalls the pipeline through stallreq_mem while a delayed read is pending.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                AW          = 14,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [WEN_W-1:0]  data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq_mem,
  output logic              addr_err
);

  localparam bit               NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dmem_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0]    r_idx;
  logic             r_oor;
  logic             r_err_sel;

  logic [AW-1:0]    w_idx, w_ridx;
  logic             w_oor, w_rd_oor;
  logic             w_accept, w_rd, w_wr, w_re;
  logic [WEN_W-1:0] w_we;
  logic [WEN_W-1:0][7:0] w_lane_q;

  assign w_idx    = data_sram_addr[AW+1:2];
  assign w_oor    = word_oor(data_sram_addr, AW);
  // RESP behaves like IDLE so a back-to-back request is not lost.
  assign w_accept = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_rd     = w_accept && data_sram_en && (data_sram_wen == '0);
  assign w_wr     = w_accept && data_sram_en && (data_sram_wen != '0);
  assign w_we     = (w_wr && !w_oor) ? data_sram_wen : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_re         = 1'b0;
    w_ridx       = w_idx;
    w_rd_oor     = w_oor;
    stallreq_mem = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        w_state_nxt = S_IDLE;
        if (w_rd) begin
          if (NO_WAIT) begin
            w_re = 1'b1;
          end else begin
            stallreq_mem = 1'b1;
            w_state_nxt  = S_WAIT;
            w_cnt_nxt    = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        stallreq_mem = 1'b1;
        w_ridx       = r_idx;
        w_rd_oor     = r_oor;
        if (r_cnt == '0) begin
          w_re        = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_oor     <= 1'b0;
      r_err_sel <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_rd) begin
        r_idx <= w_idx;
        r_oor <= w_oor;
      end
      if (w_re) r_err_sel <= w_rd_oor;
      if ((w_rd || w_wr) && w_oor) addr_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < WEN_W; g++) begin : g_lane
    dmem_byte_bank #(.AW(AW)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we[g]),
      .i_waddr (w_idx),
      .i_wdata (data_sram_wdata[8*g +: 8]),
      .i_re    (w_re),
      .i_raddr (w_ridx),
      .o_rdata (w_lane_q[g])
    );
  end

  assign data_sram_rdata = r_err_sel ? ERR_DATA : w_lane_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance A has no wait states, instance B has three.
// Each step drives one request one tick after a clock edge and checks the result.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        a_rst, a_en, a_stall, a_err;
  logic [3:0]  a_wen;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_rst, b_en, b_stall, b_err;
  logic [3:0]  b_wen;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.AW(14), .WAIT_STATES(0)) u_a (
    .clk(clk), .rst(a_rst), .data_sram_en(a_en), .data_sram_wen(a_wen),
    .data_sram_addr(a_addr), .data_sram_wdata(a_wdata),
    .data_sram_rdata(a_rdata), .stallreq_mem(a_stall), .addr_err(a_err)
  );

  dmem_responder #(.AW(14), .WAIT_STATES(3)) u_b (
    .clk(clk), .rst(b_rst), .data_sram_en(b_en), .data_sram_wen(b_wen),
    .data_sram_addr(b_addr), .data_sram_wdata(b_wdata),
    .data_sram_rdata(b_rdata), .stallreq_mem(b_stall), .addr_err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    a_en = en; a_wen = wen; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic b_req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    b_en = en; b_wen = wen; b_addr = addr; b_wdata = wdata;
  endtask

  // Issue a read on B, drop the request after the first edge (ignored while
  // waiting), count stall cycles and check data as the stall falls.
  task automatic read_b(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int sc;
    int guard;
    b_req(1'b1, 4'h0, addr, 32'h0);
    #1;
    chk({tag, "_req_stall"}, {31'h0, b_stall}, 32'd1);
    tick();
    b_req(1'b0, 4'h0, 32'h0000_0300, 32'h0);
    #1;
    sc    = 1;
    guard = 0;
    while (b_stall === 1'b1 && guard < 20) begin
      sc++;
      guard++;
      tick();
    end
    chk({tag, "_stall_cycles"}, sc, 32'd4);
    chk({tag, "_rdata"}, b_rdata, exp);
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req(1'b0, 4'h0, 32'h0, 32'h0);
    b_req(1'b0, 4'h0, 32'h0, 32'h0);
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_a_stall", {31'h0, a_stall}, 32'd0);
    chk("rst_a_err",   {31'h0, a_err},   32'd0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    chk("rst_b_stall", {31'h0, b_stall}, 32'd0);
    chk("rst_b_err",   {31'h0, b_err},   32'd0);

    // Instance A: zero wait states
    a_req(1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_F00D); tick();
    a_req(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344); tick();
    a_req(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    #1;
    chk("t1_stall", {31'h0, a_stall}, 32'd0);
    tick();
    chk("t1_rdata", a_rdata, 32'h1122_3344);

    a_req(1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD); tick();
    chk("t2_wr_hold", a_rdata, 32'h1122_3344);
    a_req(1'b1, 4'h0, 32'h0000_0100, 32'h0); tick();
    chk("t2_merge", a_rdata, 32'h11BB_33DD);

    a_req(1'b1, 4'hF, 32'h0000_0104, 32'h5566_7788); tick();
    a_req(1'b1, 4'h0, 32'h0000_0100, 32'h0); tick();
    chk("t6_rd0", a_rdata, 32'h11BB_33DD);
    a_req(1'b1, 4'hF, 32'h0000_0104, 32'h99AA_BBCC); tick();
    chk("t6_wr_hold", a_rdata, 32'h11BB_33DD);
    a_req(1'b1, 4'h0, 32'h0000_0104, 32'h0); tick();
    chk("t6_rd1", a_rdata, 32'h99AA_BBCC);
    a_req(1'b0, 4'h0, 32'h0000_0100, 32'h0); tick();
    chk("t6_idle_hold", a_rdata, 32'h99AA_BBCC);

    a_req(1'b1, 4'h0, 32'h0001_0000, 32'h0); tick();
    chk("t4_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t4_err",   {31'h0, a_err}, 32'd1);
    a_req(1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678); tick();
    a_req(1'b1, 4'h0, 32'h0000_0000, 32'h0); tick();
    chk("t4_word0", a_rdata, 32'h0BAD_F00D);
    a_req(1'b0, 4'h0, 32'h0, 32'h0); tick(); tick();
    chk("t4_err_sticky", {31'h0, a_err}, 32'd1);
    a_rst = 1'b1; tick(); a_rst = 1'b0; #1;
    chk("t4_err_rst", {31'h0, a_err}, 32'd0);
    chk("t4_rdata_rst", a_rdata, 32'h0);

    // Instance B: three wait states
    b_req(1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D);
    #1;
    chk("b_wr_stall", {31'h0, b_stall}, 32'd0);
    tick();
    b_req(1'b1, 4'hF, 32'h0000_0100, 32'h11BB_33DD); tick();
    read_b("t3", 32'h0000_0200, 32'hCAFE_F00D);
    read_b("t3_resp", 32'h0000_0100, 32'h11BB_33DD);
    read_b("t3_oor", 32'h0001_0000, 32'hDEAD_BEEF);
    chk("t3_oor_err", {31'h0, b_err}, 32'd1);

    b_req(1'b1, 4'h0, 32'h0000_0200, 32'h0); tick();
    b_req(1'b0, 4'h0, 32'h0, 32'h0);
    b_rst = 1'b1;
    #1;
    chk("t5_mid_stall", {31'h0, b_stall}, 32'd1);
    tick();
    b_rst = 1'b0;
    #1;
    chk("t5_stall", {31'h0, b_stall}, 32'd0);
    chk("t5_rdata", b_rdata, 32'h0);
    chk("t5_err",   {31'h0, b_err}, 32'd0);
    read_b("t5_fresh", 32'h0000_0100, 32'h11BB_33DD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
